// File: rtl/horizon_line_renderer.sv
// Horizon line pixel reader: snapshots segment positions per frame and
// answers per-pixel opacity queries through a 1-cycle sync sprite ROM.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   x_pos[2], bump[2]  segment left edges (signed px) and sprite variants
//   frame_start        1-cycle pulse, snapshots x_pos/bump
//   req_valid/x/y      pixel query (no back-pressure)
//   rom_addr/rom_data  sprite ROM bit address, bit returned a cycle later
//   pix_valid/pix_hit  response, 3 cycles after the query
module horizon_line_renderer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 12,
    parameter int Y_POS  = 127,
    parameter int ROM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] x_pos [2],
    input  logic               bump [2],
    input  logic               frame_start,
    input  logic               req_valid,
    input  logic [9:0]         req_x,
    input  logic [8:0]         req_y,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic               rom_data,
    output logic               pix_valid,
    output logic               pix_hit
);

    localparam logic [11:0] W12 = 12'(WIDTH);
    localparam logic [9:0]  H10 = 10'(HEIGHT);
    localparam logic [9:0]  Y10 = 10'(Y_POS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state;
    state_t state_nx;
    logic   active;

    logic [10:0] xs [2];
    logic        bs [2];

    logic [11:0]       col0;
    logic [11:0]       col1;
    logic [11:0]       colsel;
    logic [9:0]        row;
    logic              in0;
    logic              in1;
    logic              rowok;
    logic              bsel;
    logic              hit_en;
    logic [ROM_AW-1:0] addr_nx;

    logic v1;
    logic he1;
    logic v2;
    logic he2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && frame_start) state_nx = ACTIVE;
    end

    always_comb begin
        active = (state == ACTIVE);
    end

    // A query in the frame_start cycle still sees the old snapshot,
    // since these registers only change at the closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs[0] <= '0;
            xs[1] <= 11'(WIDTH);
            bs[0] <= 1'b0;
            bs[1] <= 1'b0;
        end else if (frame_start) begin
            xs[0] <= x_pos[0];
            xs[1] <= x_pos[1];
            bs[0] <= bump[0];
            bs[1] <= bump[1];
        end
    end

    // Column/row differences carry a sign bit; a set sign bit means the
    // pixel is left of (or above) the segment and is a miss.
    always_comb begin
        col0    = {2'b00, req_x} - {xs[0][10], xs[0]};
        col1    = {2'b00, req_x} - {xs[1][10], xs[1]};
        row     = {1'b0, req_y} - Y10;
        in0     = !col0[11] && (col0 < W12);
        in1     = !col1[11] && (col1 < W12);
        rowok   = !row[9] && (row < H10);
        colsel  = in0 ? col0 : col1;
        bsel    = in0 ? bs[0] : bs[1];
        addr_nx = (bsel ? ROM_AW'(HEIGHT * WIDTH) : '0)
                + ROM_AW'(row) * ROM_AW'(WIDTH)
                + ROM_AW'(colsel);
        hit_en  = req_valid && rowok && (in0 || in1) && active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            v1        <= 1'b0;
            he1       <= 1'b0;
            v2        <= 1'b0;
            he2       <= 1'b0;
            pix_valid <= 1'b0;
            pix_hit   <= 1'b0;
        end else begin
            rom_addr  <= addr_nx;
            v1        <= req_valid;
            he1       <= hit_en;
            v2        <= v1;
            he2       <= he1;
            pix_valid <= v2;
            pix_hit   <= v2 && he2 && rom_data;
        end
    end

endmodule

// File: tb/tb_horizon_line_renderer.sv
// Testbench for horizon_line_renderer: sync ROM model, per-cycle
// response model, and directed literal vectors.
module tb_horizon_line_renderer;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 12;
    localparam int Y_POS  = 127;
    localparam int ROM_AW = 14;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [10:0] x_pos [2];
    logic               bump [2];
    logic               frame_start = 1'b0;
    logic               req_valid = 1'b0;
    logic [9:0]         req_x = '0;
    logic [8:0]         req_y = '0;
    logic [ROM_AW-1:0]  rom_addr;
    logic               rom_data = 1'b0;
    logic               pix_valid;
    logic               pix_hit;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    bit rom_all_ones = 1'b1;

    always #5 clk = ~clk;

    horizon_line_renderer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .Y_POS(Y_POS), .ROM_AW(ROM_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .x_pos(x_pos), .bump(bump),
        .frame_start(frame_start),
        .req_valid(req_valid),
        .req_x(req_x), .req_y(req_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_hit(pix_hit)
    );

    function automatic bit rom_bit(input int a);
        if (rom_all_ones) return 1'b1;
        return ((a ^ (a >> 2) ^ (a >> 5)) & 1) != 0;
    endfunction

    always @(posedge clk) rom_data <= rom_bit(int'(rom_addr));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: snapshot, frame state, and queue of expected responses.
    typedef struct {
        int due;
        int addr;
        bit hit_en;
        bit hit;
    } exp_t;

    int   mx [2];
    int   mb [2];
    bit   mact;
    exp_t q [$];

    function automatic exp_t predict(input int x, input int y);
        exp_t e;
        int c0, c1, r, col, b;
        bit i0, i1, rok;
        c0  = x - mx[0];
        c1  = x - mx[1];
        r   = y - Y_POS;
        i0  = (c0 >= 0) && (c0 < WIDTH);
        i1  = (c1 >= 0) && (c1 < WIDTH);
        rok = (r >= 0) && (r < HEIGHT);
        col = i0 ? c0 : c1;
        b   = i0 ? mb[0] : mb[1];
        e.due    = cyc + 3;
        e.addr   = b * HEIGHT * WIDTH + r * WIDTH + col;
        e.hit_en = rok && (i0 || i1) && mact;
        e.hit    = e.hit_en && rom_bit(e.addr);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mx[0] <= 0;
            mx[1] <= WIDTH;
            mb[0] <= 0;
            mb[1] <= 0;
            mact  <= 1'b0;
        end else begin
            if (req_valid)
                q.push_back(predict(int'(req_x), int'(req_y)));
            if (frame_start) begin
                mx[0] <= int'(x_pos[0]);
                mx[1] <= int'(x_pos[1]);
                mb[0] <= int'(bump[0]);
                mb[1] <= int'(bump[1]);
                mact  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", int'(pix_valid), 0);
            chk("rst_hit", int'(pix_hit), 0);
            chk("rst_addr", int'(rom_addr), 0);
        end else begin
            foreach (q[i])
                if (q[i].hit_en && q[i].due - 2 == cyc)
                    chk("m_addr", int'(rom_addr), q[i].addr);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("m_valid", int'(pix_valid), 1);
                chk("m_hit", int'(pix_hit), int'(q[0].hit));
                void'(q.pop_front());
            end else begin
                chk("m_idle_valid", int'(pix_valid), 0);
                chk("m_idle_hit", int'(pix_hit), 0);
            end
        end
    end

    task automatic fstart(input int x0, input int x1,
                          input bit b0, input bit b1);
        x_pos[0]    = 11'(x0);
        x_pos[1]    = 11'(x1);
        bump[0]     = b0;
        bump[1]     = b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Single query with literal expectations; exp_addr < 0 skips addr.
    task automatic lit(input string nm, input int x, input int y,
                       input int exp_addr, input int exp_hit);
        req_valid = 1'b1;
        req_x     = 10'(x);
        req_y     = 9'(y);
        @(negedge clk);
        if (exp_addr >= 0) chk({nm, "_addr"}, int'(rom_addr), exp_addr);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, int'(pix_valid), 1);
        chk({nm, "_hit"}, int'(pix_hit), exp_hit);
    endtask

    initial begin
        x_pos[0] = '0;
        x_pos[1] = '0;
        bump[0]  = 1'b0;
        bump[1]  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle state: address computed, hit forced low.
        lit("idle", 5, 130, 1925, 0);
        fstart(0, 640, 1'b0, 1'b0);
        lit("t1", 5, 130, 1925, 1);

        // Snapshot update coinciding with a query.
        x_pos[0]    = -11'sd10;
        x_pos[1]    = 11'sd630;
        frame_start = 1'b1;
        req_valid   = 1'b1;
        req_x       = 10'd0;
        req_y       = 9'd130;
        @(negedge clk);
        chk("t5_old_addr", int'(rom_addr), 1920);
        frame_start = 1'b0;
        @(negedge clk);
        chk("t5_new_addr", int'(rom_addr), 1930);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        fstart(-100, 540, 1'b0, 1'b1);
        lit("t2_seg1", 600, 127, 7740, 1);
        lit("t2_seg0", 50, 127, 150, 1);
        lit("t3_above", 5, 126, -1, 0);
        lit("t3_below", 5, 139, -1, 0);
        lit("edge_r", 539, 138, 7679, 1);
        lit("edge_s1", 540, 138, 14720, 1);

        fstart(0, 100, 1'b1, 1'b0);
        lit("overlap", 150, 127, 7830, 1);
        fstart(10, 650, 1'b0, 1'b0);
        lit("left_miss", 5, 127, -1, 0);
        fstart(-640, 0, 1'b1, 1'b0);
        lit("neg_edge", 0, 128, 640, 1);

        // Pattern ROM, streamed queries with gaps.
        repeat (2) @(negedge clk);
        rom_all_ones = 1'b0;
        fstart(-37, 603, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_x     = 10'($urandom_range(0, 1023));
            req_y     = 9'($urandom_range(122, 142));
            if (i == 20) begin
                frame_start = 1'b1;
                x_pos[0]    = 11'sd200;
                x_pos[1]    = -11'sd440;
                bump[0]     = 1'b0;
                bump[1]     = 1'b1;
            end
            @(negedge clk);
            frame_start = 1'b0;
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back stream interrupted by reset.
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                req_valid = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                chk("t6_rst_valid", int'(pix_valid), 0);
                chk("t6_rst_hit", int'(pix_hit), 0);
                chk("t6_rst_addr", int'(rom_addr), 0);
                break;
            end
            req_valid = 1'b1;
            req_x     = 10'(i * 37);
            req_y     = 9'(127 + (i % 12));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        fstart(3, 643, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_x     = 10'(630 + i * 3);
            req_y     = 9'(130 + i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
